// File: rtl/pipelined_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_ctrl_decoder
// Description : Registered RV32IM decode/control stage between IF/ID and
//               ID/EX. Accepts one instruction per valid/ready handshake,
//               decodes all datapath controls into an output register and
//               holds issue for MUL_LAT / DIV_LAT cycles on M-extension ops.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> extra output 'illegal', registered with the bundle
//   undefined -> illegal encodings become all-zero control bubbles
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-low reset
//   in_valid   in   instr is valid
//   in_ready   out  stage can accept instr this cycle
//   instr      in   [31:0] RV32 instruction word
//   flush      in   discard held / in-progress instruction
//   out_valid  out  control bundle is valid
//   out_ready  in   downstream consumes bundle this cycle
//   reg_write, mem_write, mem_read, alu_src, branch, jump, jump_reg,
//   b_zero     out  single-bit controls
//   result_src out  [1:0] 00 ALU, 01 mem, 10 PC+4
//   imm_type   out  [2:0] 000 I, 001 S, 010 B, 011 U, 100 J
//   alu_ctrl   out  [ALUCTRL_W-1:0] ALU operation
//   pc_sel     out  [1:0] 00 normal, 01 AUIPC, 10 LUI
//   busy       out  multi-cycle op in progress
//   illegal    out  (ILLEGAL_TRAP_EN only) bundle came from illegal encoding
// ============================================================================
module pipelined_ctrl_decoder #(
    parameter int ALUCTRL_W = 5,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 33,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic                 alu_src,
    output logic                 branch,
    output logic                 jump,
    output logic                 jump_reg,
    output logic                 b_zero,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_type,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [1:0]           pc_sel,
    output logic                 busy
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                 illegal
`endif
);

    // ------------------------------------------------------------------
    // Opcodes and ALU encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    localparam logic [ALUCTRL_W-1:0] c_ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] c_ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] c_ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] c_ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SLT  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SLTU = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SLL  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SRL  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] c_ALU_SRA  = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] c_ALU_MUL  = ALUCTRL_W'(10);

    localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_MULTI = 2'd2
    } state_t;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 mem_read;
        logic                 alu_src;
        logic                 branch;
        logic                 jump;
        logic                 jump_reg;
        logic                 b_zero;
        logic [1:0]           result_src;
        logic [2:0]           imm_type;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [1:0]           pc_sel;
        logic                 illegal;
    } ctrl_t;

    // Register-register / register-immediate share one funct3 mapping;
    // SUB and SRA are resolved by the caller from funct7.
    function automatic logic [ALUCTRL_W-1:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_from_f3 = c_ALU_ADD;
            3'b001:  alu_from_f3 = c_ALU_SLL;
            3'b010:  alu_from_f3 = c_ALU_SLT;
            3'b011:  alu_from_f3 = c_ALU_SLTU;
            3'b100:  alu_from_f3 = c_ALU_XOR;
            3'b101:  alu_from_f3 = c_ALU_SRL;
            3'b110:  alu_from_f3 = c_ALU_OR;
            default: alu_from_f3 = c_ALU_AND;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_t             ctrl_q, ctrl_d;
    ctrl_t             w_dec;
    logic              w_is_m;
    logic              w_ill;
    logic              w_accept;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic              w_unused_instr;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_unused_instr = ^{instr[24:15], instr[11:7]};

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec  = '0;
        w_is_m = 1'b0;
        w_ill  = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_dec.reg_write = 1'b1;
                case (w_funct7)
                    c_F7_BASE: w_dec.alu_ctrl = alu_from_f3(w_funct3);
                    c_F7_ALT: begin
                        if (w_funct3 == 3'b000)      w_dec.alu_ctrl = c_ALU_SUB;
                        else if (w_funct3 == 3'b101) w_dec.alu_ctrl = c_ALU_SRA;
                        else                         w_ill = 1'b1;
                    end
                    c_F7_MULDIV: begin
                        // MUL..REMU are numbered consecutively from MUL in funct3 order
                        w_is_m         = 1'b1;
                        w_dec.alu_ctrl = c_ALU_MUL + ALUCTRL_W'(w_funct3);
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            c_OP_IMM: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = alu_from_f3(w_funct3);
                if (w_funct3 == 3'b001 && w_funct7 != c_F7_BASE) begin
                    w_ill = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    if (w_funct7 == c_F7_ALT)       w_dec.alu_ctrl = c_ALU_SRA;
                    else if (w_funct7 != c_F7_BASE) w_ill = 1'b1;
                end
            end
            c_OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b01;
                // LB LH LW LBU LHU only
                if (w_funct3 == 3'b011 || w_funct3[2:1] == 2'b11) w_ill = 1'b1;
            end
            c_OP_STORE: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_type  = 3'b001;
                if (w_funct3[2] || w_funct3 == 3'b011) w_ill = 1'b1;
            end
            c_OP_BRANCH: begin
                w_dec.branch   = 1'b1;
                w_dec.imm_type = 3'b010;
                case (w_funct3)
                    3'b000:  begin w_dec.alu_ctrl = c_ALU_SUB;  w_dec.b_zero = 1'b0; end
                    3'b001:  begin w_dec.alu_ctrl = c_ALU_SUB;  w_dec.b_zero = 1'b1; end
                    3'b100:  begin w_dec.alu_ctrl = c_ALU_SLT;  w_dec.b_zero = 1'b1; end
                    3'b101:  begin w_dec.alu_ctrl = c_ALU_SLT;  w_dec.b_zero = 1'b0; end
                    3'b110:  begin w_dec.alu_ctrl = c_ALU_SLTU; w_dec.b_zero = 1'b1; end
                    3'b111:  begin w_dec.alu_ctrl = c_ALU_SLTU; w_dec.b_zero = 1'b0; end
                    default: w_ill = 1'b1;
                endcase
            end
            c_OP_LUI: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_type  = 3'b011;
                w_dec.pc_sel    = 2'b10;
            end
            c_OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_type  = 3'b011;
                w_dec.pc_sel    = 2'b01;
            end
            c_OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.imm_type   = 3'b100;
            end
            c_OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jump_reg   = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b10;
                if (w_funct3 != 3'b000) w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase

        // Illegal encodings travel as an all-zero bubble
        if (w_ill) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
            w_is_m        = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready = rst & ~flush &
                      ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
    assign w_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ctrl_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        ctrl_d = w_dec;
                        if (w_is_m) begin
                            state_d = S_MULTI;
                            cnt_d   = w_funct3[2] ? c_DIV_CNT : c_MUL_CNT;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else if (state_q == S_HOLD && out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_MULTI: begin
                    if (cnt_q == '0) state_d = S_HOLD;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = (state_q == S_HOLD);
    assign busy       = (state_q == S_MULTI);
    assign reg_write  = ctrl_q.reg_write;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_read   = ctrl_q.mem_read;
    assign alu_src    = ctrl_q.alu_src;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign jump_reg   = ctrl_q.jump_reg;
    assign b_zero     = ctrl_q.b_zero;
    assign result_src = ctrl_q.result_src;
    assign imm_type   = ctrl_q.imm_type;
    assign alu_ctrl   = ctrl_q.alu_ctrl;
    assign pc_sel     = ctrl_q.pc_sel;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = ctrl_q.illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = ctrl_q.illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_ctrl_decoder
// Description : Self-checking bench for pipelined_ctrl_decoder. Expected
//               control bundles are queued on accept and compared when the
//               stage hands a bundle downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_ctrl_decoder;

    localparam int ALUCTRL_W = 5;
    localparam int MUL_LAT   = 2;
    localparam int DIV_LAT   = 33;
    localparam int CNT_W     = 6;
    localparam int c_LAT_1   = 1;
    localparam int c_LAT_MUL = MUL_LAT + 1;
    localparam int c_LAT_DIV = DIV_LAT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        reg_write, mem_write, mem_read, alu_src, branch, jump, jump_reg, b_zero;
    logic [1:0]  result_src;
    logic [2:0]  imm_type;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [1:0]  pc_sel;
    logic        busy;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    pipelined_ctrl_decoder #(
        .ALUCTRL_W (ALUCTRL_W),
        .MUL_LAT   (MUL_LAT),
        .DIV_LAT   (DIV_LAT),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .alu_src    (alu_src),
        .branch     (branch),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .b_zero     (b_zero),
        .result_src (result_src),
        .imm_type   (imm_type),
        .alu_ctrl   (alu_ctrl),
        .pc_sel     (pc_sel),
        .busy       (busy)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    // Bundle order: rw mw mr as br j jr bz | rs[1:0] | imm[2:0] | alu[4:0] | pc[1:0]
    logic [19:0] w_act;
    assign w_act = {reg_write, mem_write, mem_read, alu_src, branch, jump, jump_reg, b_zero,
                    result_src, imm_type, alu_ctrl, pc_sel};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [19:0] mk(input bit rw, input bit mw, input bit mr, input bit as,
                                       input bit br, input bit j, input bit jr, input bit bz,
                                       input bit [1:0] rs, input bit [2:0] imm,
                                       input int alu, input bit [1:0] pc);
        logic [4:0] a;
        a = alu[4:0];
        return {rw, mw, mr, as, br, j, jr, bz, rs, imm, a, pc};
    endfunction

    // Instruction with fixed registers: only opcode/funct3/funct7 matter here
    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] op);
        return {f7, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic [19:0] exp;
        logic        ill;
        int          lat;
        int          acc_cyc;
    } sb_t;

    sb_t         sb[$];
    string       cur_name;
    logic [19:0] cur_exp;
    logic        cur_ill;
    int          cur_lat;
    int          cyc  = 0;
    bit          seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst !== 1'b1 || flush === 1'b1) begin
            sb.delete();
            seen = 1'b0;
        end else begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        chk({sb[0].name, "_latency"}, cyc - sb[0].acc_cyc, sb[0].lat);
                        seen = 1'b1;
                    end
                    if (out_ready === 1'b1) begin
                        chk({sb[0].name, "_bundle"}, {12'd0, w_act}, {12'd0, sb[0].exp});
`ifdef ILLEGAL_TRAP_EN
                        chk({sb[0].name, "_illegal"}, {31'd0, illegal}, {31'd0, sb[0].ill});
`endif
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1)
                sb.push_back('{cur_name, cur_exp, cur_ill, cur_lat, cyc});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input string nm, input logic [31:0] ins, input logic [19:0] e,
                        input logic il, input int lat, output int waits);
        cur_name = nm;
        cur_exp  = e;
        cur_ill  = il;
        cur_lat  = lat;
        instr    = ins;
        in_valid = 1'b1;
        waits    = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waits++;
        end
        if (in_ready !== 1'b1) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_queue_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [19:0] exp;
        logic        ill;
        int          lat;
    } stim_t;

    stim_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, cnt, bad;
        logic [19:0] e_lw, e_addi, e_div;

        e_lw   = mk(1,0,1,1,0,0,0,0, 2'b01, 3'b000, 0, 2'b00);
        e_addi = mk(1,0,0,1,0,0,0,0, 2'b00, 3'b000, 0, 2'b00);
        e_div  = mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 14, 2'b00);

        tbl.push_back('{"SUB",    enc(7'b0100000, 3'b000, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 1, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"SRA",    enc(7'b0100000, 3'b101, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 9, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"XOR",    enc(7'b0000000, 3'b100, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 4, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"SLTU",   enc(7'b0000000, 3'b011, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 6, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"R_BADF7",enc(7'b0100000, 3'b001, 7'b0110011), 20'd0, 1'b1, c_LAT_1});
        tbl.push_back('{"LW",     enc(7'b0000000, 3'b010, 7'b0000011), e_lw, 1'b0, c_LAT_1});
        tbl.push_back('{"SW",     enc(7'b0000000, 3'b010, 7'b0100011), mk(0,1,0,1,0,0,0,0, 2'b00, 3'b001, 0, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"ADDI",   enc(7'b0000000, 3'b000, 7'b0010011), e_addi, 1'b0, c_LAT_1});
        tbl.push_back('{"SRAI",   enc(7'b0100000, 3'b101, 7'b0010011), mk(1,0,0,1,0,0,0,0, 2'b00, 3'b000, 9, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"SLLI_BAD",enc(7'b0100000, 3'b001, 7'b0010011), 20'd0, 1'b1, c_LAT_1});
        tbl.push_back('{"ORI",    enc(7'b0000000, 3'b110, 7'b0010011), mk(1,0,0,1,0,0,0,0, 2'b00, 3'b000, 3, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"LUI",    enc(7'b0000000, 3'b000, 7'b0110111), mk(1,0,0,1,0,0,0,0, 2'b00, 3'b011, 0, 2'b10), 1'b0, c_LAT_1});
        tbl.push_back('{"AUIPC",  enc(7'b0000000, 3'b000, 7'b0010111), mk(1,0,0,1,0,0,0,0, 2'b00, 3'b011, 0, 2'b01), 1'b0, c_LAT_1});
        tbl.push_back('{"JAL",    enc(7'b0000000, 3'b000, 7'b1101111), mk(1,0,0,0,0,1,0,0, 2'b10, 3'b100, 0, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"JALR",   enc(7'b0000000, 3'b000, 7'b1100111), mk(1,0,0,1,0,0,1,0, 2'b10, 3'b000, 0, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"BLT",    enc(7'b0000000, 3'b100, 7'b1100011), mk(0,0,0,0,1,0,0,1, 2'b00, 3'b010, 5, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"BGE",    enc(7'b0000000, 3'b101, 7'b1100011), mk(0,0,0,0,1,0,0,0, 2'b00, 3'b010, 5, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"BEQ",    enc(7'b0000000, 3'b000, 7'b1100011), mk(0,0,0,0,1,0,0,0, 2'b00, 3'b010, 1, 2'b00), 1'b0, c_LAT_1});
        tbl.push_back('{"BR_F3_010",enc(7'b0000000, 3'b010, 7'b1100011), 20'd0, 1'b1, c_LAT_1});
        tbl.push_back('{"OPC_7F", enc(7'b0000000, 3'b000, 7'b1111111), 20'd0, 1'b1, c_LAT_1});
        tbl.push_back('{"MUL",    enc(7'b0000001, 3'b000, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 10, 2'b00), 1'b0, c_LAT_MUL});
        tbl.push_back('{"MULHU",  enc(7'b0000001, 3'b011, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 13, 2'b00), 1'b0, c_LAT_MUL});
        tbl.push_back('{"REMU",   enc(7'b0000001, 3'b111, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 17, 2'b00), 1'b0, c_LAT_DIV});
        tbl.push_back('{"AND",    enc(7'b0000000, 3'b111, 7'b0110011), mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 2, 2'b00), 1'b0, c_LAT_1});

        // Reset with a pending valid instruction
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = enc(7'b0000000, 3'b000, 7'b0110011);
        cur_name  = "none";
        cur_exp   = '0;
        cur_ill   = 1'b0;
        cur_lat   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_bundle",    {12'd0, w_act},     32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_in_ready",  {31'd0, in_ready},  32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // ADD, then BNE/BGEU back-to-back with no wait states
        send("ADD", enc(7'b0000000, 3'b000, 7'b0110011),
             mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 0, 2'b00), 1'b0, c_LAT_1, w);
        send("BNE", enc(7'b0000000, 3'b001, 7'b1100011),
             mk(0,0,0,0,1,0,0,1, 2'b00, 3'b010, 1, 2'b00), 1'b0, c_LAT_1, w);
        send("BGEU", enc(7'b0000000, 3'b111, 7'b1100011),
             mk(0,0,0,0,1,0,0,0, 2'b00, 3'b010, 6, 2'b00), 1'b0, c_LAT_1, w2);
        chk("bne_wait_states",  w,  32'd0);
        chk("bgeu_wait_states", w2, 32'd0);

        // Streamed decode table
        foreach (tbl[i]) send(tbl[i].name, tbl[i].ins, tbl[i].exp, tbl[i].ill, tbl[i].lat, w);
        drain();

        // DIV: busy for DIV_LAT cycles with in_ready low
        send("DIV", enc(7'b0000001, 3'b100, 7'b0110011), e_div, 1'b0, c_LAT_DIV, w);
        cnt = 0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            if (busy === 1'b1) begin
                cnt++;
                if (in_ready !== 1'b0) bad++;
            end
        end
        chk("div_busy_cycles",   cnt, DIV_LAT);
        chk("div_in_ready_low",  bad, 32'd0);
        chk("div_out_valid",     {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: LW held 5 cycles while a second instruction waits
        out_ready = 1'b0;
        send("LW_STALL", enc(7'b0000000, 3'b010, 7'b0000011), e_lw, 1'b0, c_LAT_1, w);
        instr    = enc(7'b0000000, 3'b000, 7'b0010011);
        in_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || w_act !== e_lw) bad++;
        end
        chk("stall_bundle_stable", bad, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send("ADDI_AFTER_STALL", enc(7'b0000000, 3'b000, 7'b0010011), e_addi, 1'b0, c_LAT_1, w);
        chk("stall_release_wait", w, 32'd0);
        drain();

        // Flush on cycle 10 of a DIV
        send("DIV_FLUSH", enc(7'b0000001, 3'b100, 7'b0110011), e_div, 1'b0, c_LAT_DIV, w);
        repeat (9) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_busy",      {31'd0, busy},      32'd0);
        chk("post_flush_in_ready",  {31'd0, in_ready},  32'd1);
        cnt = 0;
        repeat (40) begin
            if (out_valid === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("post_flush_no_output", cnt, 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a DIV
        send("DIV_RESET", enc(7'b0000001, 3'b100, 7'b0110011), e_div, 1'b0, c_LAT_DIV, w);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy",     {31'd0, busy},     32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_bundle",   {12'd0, w_act},    32'd0);
        cnt = 0;
        repeat (40) begin
            if (out_valid === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("post_rst_no_output", cnt, 32'd0);
        @(posedge clk);
        #1;

        // Stage still works after the abort
        send("MUL_FINAL", enc(7'b0000001, 3'b000, 7'b0110011),
             mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 10, 2'b00), 1'b0, c_LAT_MUL, w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
